// File: rtl/gb_xact_engine.sv
// Self-test ghostbus master: writes a generated pattern over an address walk, reads it back pipelined, and compares under a mask.
// Optional macro GB_XACT_LFSR_EN selects a 32-bit Galois LFSR pattern in place of the incrementing seed+i pattern.
module gb_xact_engine #(
    parameter int AW         = 24,
    parameter int DW         = 32,
    parameter int READ_DELAY = 3,
    parameter int CW         = 16,
    parameter int ERRW       = 16
) (
    input  logic            gb_clk,
    input  logic            gb_rst,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic [AW-1:0]   base_addr,
    input  logic [AW-1:0]   stride,
    input  logic [CW-1:0]   count,
    input  logic [DW-1:0]   seed,
    input  logic [DW-1:0]   mask,
    output logic            busy,
    output logic            done,
    output logic [ERRW-1:0] err_count,
    output logic [AW-1:0]   fail_addr,
    output logic [DW-1:0]   fail_exp,
    output logic [DW-1:0]   fail_got,
    output logic [AW-1:0]   gb_addr,
    output logic [DW-1:0]   gb_wdata,
    output logic            gb_wen,
    output logic            gb_rstb,
    input  logic [DW-1:0]   gb_rdata
);

`ifdef GB_XACT_LFSR_EN
    localparam int PW = 32;

    function automatic logic [PW-1:0] pat_init(input logic [DW-1:0] s);
        logic [31:0] s32;
        s32 = 32'(s);
        return (s32 == 32'd0) ? 32'd1 : s32;
    endfunction

    // Right-shifting Galois form of x^32+x^22+x^2+x+1
    function automatic logic [PW-1:0] pat_next(input logic [PW-1:0] p);
        return {1'b0, p[31:1]} ^ (p[0] ? 32'h8020_0003 : 32'd0);
    endfunction

    function automatic logic [DW-1:0] pat_word(input logic [PW-1:0] p);
        logic [DW-1:0] w;
        for (int b = 0; b < DW; b++) w[b] = p[b % 32];
        return w;
    endfunction
`else
    localparam int PW = DW;

    function automatic logic [PW-1:0] pat_init(input logic [DW-1:0] s);
        return s;
    endfunction

    function automatic logic [PW-1:0] pat_next(input logic [PW-1:0] p);
        return p + PW'(1);
    endfunction

    function automatic logic [DW-1:0] pat_word(input logic [PW-1:0] p);
        return p;
    endfunction
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_GAP, S_READ, S_DRAIN, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q;
    logic [AW-1:0]   base_q, stride_q, addr_q, addr_d;
    logic [CW-1:0]   count_q, idx_q, idx_d;
    logic [DW-1:0]   seed_q, mask_q;
    logic [PW-1:0]   pat_q, pat_d;
    logic [ERRW-1:0] err_q;
    logic [AW-1:0]   faddr_q;
    logic [DW-1:0]   fexp_q, fgot_q;

    // Expected-data pipe, aligned so its last stage meets gb_rdata
    logic [READ_DELAY-1:0] pv_q;
    logic [AW-1:0]         pa_q [READ_DELAY];
    logic [DW-1:0]         pe_q [READ_DELAY];

    logic accept, last, push, miss;
    logic [DW-1:0] got_m;

    assign last  = (idx_q == count_q - CW'(1));
    assign push  = (state_q == S_READ);
    assign got_m = gb_rdata & mask_q;
    assign miss  = pv_q[READ_DELAY-1] && (got_m != pe_q[READ_DELAY-1]);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                accept  = 1'b1;
                addr_d  = base_addr;
                pat_d   = pat_init(seed);
                idx_d   = '0;
                state_d = (mode[0] && count != '0) ? S_WRITE : S_GAP;
            end
            S_WRITE: begin
                if (last) begin
                    state_d = S_GAP;
                    addr_d  = base_q;
                    pat_d   = pat_init(seed_q);
                    idx_d   = '0;
                end else begin
                    addr_d = addr_q + stride_q;
                    pat_d  = pat_next(pat_q);
                    idx_d  = idx_q + CW'(1);
                end
            end
            S_GAP:   state_d = (mode_q[1] && count_q != '0) ? S_READ : S_DONE;
            S_READ: begin
                addr_d = addr_q + stride_q;
                pat_d  = pat_next(pat_q);
                idx_d  = idx_q + CW'(1);
                if (last) state_d = S_DRAIN;
            end
            S_DRAIN: if (pv_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            state_q  <= S_IDLE;
            mode_q   <= '0;
            base_q   <= '0;
            stride_q <= '0;
            count_q  <= '0;
            seed_q   <= '0;
            mask_q   <= '0;
            addr_q   <= '0;
            pat_q    <= '0;
            idx_q    <= '0;
            err_q    <= '0;
            faddr_q  <= '0;
            fexp_q   <= '0;
            fgot_q   <= '0;
            pv_q     <= '0;
            for (int k = 0; k < READ_DELAY; k++) begin
                pa_q[k] <= '0;
                pe_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            if (accept) begin
                mode_q   <= mode;
                base_q   <= base_addr;
                stride_q <= stride;
                count_q  <= count;
                seed_q   <= seed;
                mask_q   <= mask;
                err_q    <= '0;
                faddr_q  <= '0;
                fexp_q   <= '0;
                fgot_q   <= '0;
            end else if (miss) begin
                if (err_q != '1) err_q <= err_q + ERRW'(1);
                if (err_q == '0) begin
                    faddr_q <= pa_q[READ_DELAY-1];
                    fexp_q  <= pe_q[READ_DELAY-1];
                    fgot_q  <= got_m;
                end
            end
            for (int k = READ_DELAY - 1; k > 0; k--) begin
                pv_q[k] <= pv_q[k-1];
                pa_q[k] <= pa_q[k-1];
                pe_q[k] <= pe_q[k-1];
            end
            pv_q[0] <= push;
            pa_q[0] <= addr_q;
            pe_q[0] <= pat_word(pat_q) & mask_q;
        end
    end

    assign gb_wen    = (state_q == S_WRITE);
    assign gb_rstb   = (state_q == S_READ);
    assign gb_addr   = (gb_wen || gb_rstb) ? addr_q : '0;
    assign gb_wdata  = gb_wen ? pat_word(pat_q) : '0;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign err_count = err_q;
    assign fail_addr = faddr_q;
    assign fail_exp  = fexp_q;
    assign fail_got  = fgot_q;

endmodule

// File: tb/tb_gb_xact_engine.sv
// Bench for gb_xact_engine: RAM model on the ghostbus, scoreboard of expected bus strobes and done results.
module tb_gb_xact_engine;
    localparam int AW = 24, DW = 32, RD = 3, CW = 16, ERRW = 16;

    logic            gb_clk = 1'b0;
    logic            gb_rst = 1'b1;
    logic            start  = 1'b0;
    logic [1:0]      mode   = '0;
    logic [AW-1:0]   base_addr = '0, stride = '0;
    logic [CW-1:0]   count  = '0;
    logic [DW-1:0]   seed   = '0, mask = '0;
    logic            busy, done, gb_wen, gb_rstb;
    logic [ERRW-1:0] err_count;
    logic [AW-1:0]   fail_addr, gb_addr;
    logic [DW-1:0]   fail_exp, fail_got, gb_wdata, gb_rdata;

    gb_xact_engine #(.AW(AW), .DW(DW), .READ_DELAY(RD), .CW(CW), .ERRW(ERRW)) dut (
        .gb_clk(gb_clk), .gb_rst(gb_rst), .start(start), .mode(mode),
        .base_addr(base_addr), .stride(stride), .count(count), .seed(seed), .mask(mask),
        .busy(busy), .done(done), .err_count(err_count), .fail_addr(fail_addr),
        .fail_exp(fail_exp), .fail_got(fail_got), .gb_addr(gb_addr), .gb_wdata(gb_wdata),
        .gb_wen(gb_wen), .gb_rstb(gb_rstb), .gb_rdata(gb_rdata)
    );

    always #5 gb_clk = ~gb_clk;

    int checks = 0, failures = 0;
    int cyc = 0, start_cyc = 0;
    bit sb_en = 1'b1;

    always @(posedge gb_clk) cyc <= cyc + 1;

    // RAM model; address 0x01 optionally behaves as a 4-bit CSR, one address can be forced to read 0
    logic [31:0]   mem [logic [23:0]];
    logic [31:0]   rdp [RD];
    bit            narrow_en = 1'b0, fault_en = 1'b0;
    logic [AW-1:0] fault_addr = '0;

    function automatic logic [31:0] rd_val(input logic [23:0] a);
        if (fault_en && a == fault_addr) return 32'd0;
        if (mem.exists(a)) return mem[a];
        return 32'd0;
    endfunction

    always @(posedge gb_clk) begin
        if (gb_wen) mem[gb_addr] = (narrow_en && gb_addr == 24'h1) ? (gb_wdata & 32'hf) : gb_wdata;
        rdp[0] <= gb_rstb ? rd_val(gb_addr) : 32'd0;
        for (int k = 1; k < RD; k++) rdp[k] <= rdp[k-1];
    end
    assign gb_rdata = rdp[RD-1];

    function automatic logic [31:0] pat(input logic [31:0] s, input int i);
        logic [31:0] p;
`ifdef GB_XACT_LFSR_EN
        p = (s == 32'd0) ? 32'd1 : s;
        for (int k = 0; k < i; k++) p = {1'b0, p[31:1]} ^ (p[0] ? 32'h8020_0003 : 32'd0);
`else
        p = s + 32'(i);
`endif
        return p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", nm, got, exp);
        end
    endtask

    typedef struct {
        int            kind;   // 0 write, 1 read, 2 done
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [ERRW-1:0] err;
        logic [AW-1:0] fa;
        logic [DW-1:0] fe, fg;
        int            lat;
    } exp_t;
    exp_t sbq[$];

    task automatic pop_cmp(input int kind);
        exp_t e;
        if (sbq.size() == 0) begin
            chk("sb_unexpected_output", 64'(kind), 64'hffff);
            return;
        end
        e = sbq.pop_front();
        chk("sb_kind", 64'(kind), 64'(e.kind));
        if (kind != e.kind) return;
        case (kind)
            0: begin
                chk("wr_addr", 64'(gb_addr), 64'(e.addr));
                chk("wr_data", 64'(gb_wdata), 64'(e.data));
                chk("busy_wr", 64'(busy), 64'd1);
            end
            1: begin
                chk("rd_addr", 64'(gb_addr), 64'(e.addr));
                chk("busy_rd", 64'(busy), 64'd1);
            end
            default: begin
                chk("err_count", 64'(err_count), 64'(e.err));
                chk("fail_addr", 64'(fail_addr), 64'(e.fa));
                chk("fail_exp", 64'(fail_exp), 64'(e.fe));
                chk("fail_got", 64'(fail_got), 64'(e.fg));
                chk("done_latency", 64'(cyc - start_cyc + 1), 64'(e.lat));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        endcase
    endtask

    // Monitor: decoupled from stimulus, consumes scoreboard entries as the DUT presents them
    always @(negedge gb_clk) begin
        if (!gb_rst && sb_en) begin
            if (gb_wen && gb_rstb) chk("strobe_overlap", 64'd1, 64'd0);
            if (gb_wen)  pop_cmp(0);
            if (gb_rstb) pop_cmp(1);
            if (done)    pop_cmp(2);
        end
    end

    task automatic expect_run(input logic [AW-1:0] b, input logic [AW-1:0] st, input int n,
                              input logic [1:0] md, input logic [DW-1:0] sd,
                              input logic [ERRW-1:0] er, input logic [AW-1:0] fa,
                              input logic [DW-1:0] fe, input logic [DW-1:0] fg, input int lat);
        exp_t e;
        logic [AW-1:0] a;
        e = '{kind: 0, addr: '0, data: '0, err: '0, fa: '0, fe: '0, fg: '0, lat: 0};
        for (int ph = 0; ph < 2; ph++) begin
            if (md[ph]) begin
                a = b;
                for (int i = 0; i < n; i++) begin
                    e.kind = ph; e.addr = a; e.data = pat(sd, i);
                    sbq.push_back(e);
                    a = a + st;
                end
            end
        end
        e.kind = 2; e.err = er; e.fa = fa; e.fe = fe; e.fg = fg; e.lat = lat;
        sbq.push_back(e);
    endtask

    task automatic issue(input logic [AW-1:0] b, input logic [AW-1:0] st, input int n,
                         input logic [1:0] md, input logic [DW-1:0] sd, input logic [DW-1:0] mk);
        @(negedge gb_clk);
        base_addr = b; stride = st; count = CW'(n); mode = md; seed = sd; mask = mk;
        start = 1'b1;
        @(posedge gb_clk);
        #1 start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge gb_clk);
            if (done) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
        @(negedge gb_clk);
        chk("done_single_pulse", 64'(done), 64'd0);
        @(negedge gb_clk);
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        sbq.delete();
    endtask

    task automatic run(input logic [AW-1:0] b, input logic [AW-1:0] st, input int n,
                       input logic [1:0] md, input logic [DW-1:0] sd, input logic [DW-1:0] mk,
                       input logic [ERRW-1:0] er, input logic [AW-1:0] fa,
                       input logic [DW-1:0] fe, input logic [DW-1:0] fg, input int lat,
                       input bit poke);
        expect_run(b, st, n, md, sd, er, fa, fe, fg, lat);
        issue(b, st, n, md, sd, mk);
        if (poke) begin
            repeat (4) @(negedge gb_clk);
            base_addr = 24'h555; count = 16'd3; mode = 2'b01; seed = '0; mask = '0;
            start = 1'b1;
            @(posedge gb_clk);
            #1 start = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        bit seen;
        repeat (3) @(posedge gb_clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_strobes", 64'({gb_wen, gb_rstb}), 64'd0);
        chk("rst_bus", 64'({gb_addr, gb_wdata}), 64'd0);
        chk("rst_results", 64'({err_count, fail_addr}), 64'd0);
        chk("rst_fail_data", 64'({fail_exp, fail_got}), 64'd0);
        @(negedge gb_clk);
        gb_rst = 1'b0;

        // basic walk, with a start pulse and changed inputs mid-run that must be ignored
        run(24'h20, 24'h1, 8, 2'b11, 32'hd0, 32'hff, 16'd0, 24'h0, 32'h0, 32'h0, 22, 1'b1);

        // single forced read fault at 0x23
        fault_en = 1'b1; fault_addr = 24'h23;
`ifndef GB_XACT_LFSR_EN
        run(24'h20, 24'h1, 8, 2'b11, 32'hd0, 32'hff, 16'd1, 24'h23, 32'hd3, 32'h00, 22, 1'b0);
`endif
        fault_en = 1'b0;

        // count=0 clears previous failure results and finishes in 2 cycles
        run(24'h20, 24'h1, 0, 2'b11, 32'hd0, 32'hff, 16'd0, 24'h0, 32'h0, 32'h0, 2, 1'b0);
        run(24'h20, 24'h1, 5, 2'b00, 32'hd0, 32'hff, 16'd0, 24'h0, 32'h0, 32'h0, 2, 1'b0);

`ifndef GB_XACT_LFSR_EN
        // 4-bit CSR at 0x01: passes with narrow mask, fails with byte mask
        narrow_en = 1'b1;
        run(24'h01, 24'h1, 1, 2'b11, 32'ha5, 32'hf, 16'd0, 24'h0, 32'h0, 32'h0, 8, 1'b0);
        run(24'h01, 24'h1, 1, 2'b11, 32'ha5, 32'hff, 16'd1, 24'h01, 32'ha5, 32'h05, 8, 1'b0);
        narrow_en = 1'b0;

        // stride 0: last write wins, first two reads mismatch
        run(24'h40, 24'h0, 3, 2'b11, 32'h10, 32'hff, 16'd2, 24'h40, 32'h10, 32'h12, 12, 1'b0);
`endif

        // address wrap at top of the 24-bit space
        run(24'hfffffe, 24'h1, 4, 2'b11, 32'h100, 32'hffffffff, 16'd0, 24'h0, 32'h0, 32'h0, 14, 1'b0);

        // reset during READ with a pending error
        sb_en = 1'b0; fault_en = 1'b1; fault_addr = 24'h20;
        issue(24'h20, 24'h1, 8, 2'b11, 32'hd0, 32'hff);
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge gb_clk);
            if (gb_rstb) seen = 1'b1;
        end
        if (!seen) chk("read_phase_timeout", 64'd0, 64'd1);
        repeat (5) @(negedge gb_clk);
        chk("err_before_reset", 64'(err_count), 64'd1);
        chk("rstb_before_reset", 64'(gb_rstb), 64'd1);
        gb_rst = 1'b1;
        @(posedge gb_clk);
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_strobes", 64'({gb_wen, gb_rstb}), 64'd0);
        chk("midrst_err", 64'(err_count), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        @(negedge gb_clk);
        gb_rst = 1'b0; fault_en = 1'b0; sb_en = 1'b1;
        run(24'h20, 24'h1, 8, 2'b11, 32'hd0, 32'hff, 16'd0, 24'h0, 32'h0, 32'h0, 22, 1'b0);

`ifdef GB_XACT_LFSR_EN
        // seed 0 maps to 1; pattern 0x1, 0x80200003
        run(24'h80, 24'h4, 2, 2'b11, 32'h0, 32'hffffffff, 16'd0, 24'h0, 32'h0, 32'h0, 10, 1'b0);
        chk("lfsr_model_p0", 64'(pat(32'h0, 0)), 64'h1);
        chk("lfsr_model_p1", 64'(pat(32'h0, 1)), 64'h8020_0003);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
